// File: rtl/rr_arbiter_5req.sv
// Five-way round-robin arbiter that holds a registered grant until done, request drop or hold limit.
// Grant and clear each take 1 cycle; there is no backpressure, and losing requesters simply keep requesting.
module rr_arbiter_5req #(
  parameter int MAX_HOLD = 15,
  parameter int CNT_W    = 8
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [4:0] req_i,
  input  logic       done_i,
  output logic [4:0] gnt_o,
  output logic [2:0] gnt_idx_o,
  output logic       gnt_valid_o,
  output logic       timeout_o
);

  typedef enum logic {IDLE, BUSY} state_t;

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  state_t           state_q, state_d;
  logic [2:0]       last_idx_q, last_idx_d;
  logic [CNT_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [4:0]       gnt_d;
  logic [2:0]       gnt_idx_d;
  logic             gnt_valid_d, timeout_d;

  logic [4:0] mask, masked;
  logic [2:0] win_idx;
  logic       win_vld;
  logic       owner_req, at_limit, release_now;

  // Rotating priority: requesters above the last winner first, else wrap to the lowest index.
  always_comb begin
    mask = '0;
    for (int k = 0; k < 5; k++) mask[k] = (3'(k) > last_idx_q);
    masked  = req_i & mask;
    win_vld = |req_i;
    win_idx = '0;
    for (int k = 4; k >= 0; k--) if (req_i[k]) win_idx = 3'(k);
    for (int k = 4; k >= 0; k--) if (masked[k]) win_idx = 3'(k);
  end

  assign owner_req   = req_i[gnt_idx_o];
  assign at_limit    = (hold_cnt_q == HOLD_LAST);
  assign release_now = done_i | ~owner_req | at_limit;

  always_comb begin
    state_d     = state_q;
    last_idx_d  = last_idx_q;
    hold_cnt_d  = hold_cnt_q;
    gnt_d       = gnt_o;
    gnt_idx_d   = gnt_idx_o;
    gnt_valid_d = gnt_valid_o;
    timeout_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_vld) begin
          state_d     = BUSY;
          gnt_d       = 5'b00001 << win_idx;
          gnt_idx_d   = win_idx;
          gnt_valid_d = 1'b1;
          last_idx_d  = win_idx;
          hold_cnt_d  = '0;
        end
      end
      BUSY: begin
        if (release_now) begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_idx_d   = '0;
          gnt_valid_d = 1'b0;
          hold_cnt_d  = '0;
          // Timeout is only flagged when the limit alone forced the release.
          timeout_d   = at_limit & ~done_i & owner_req;
        end else begin
          hold_cnt_d = hold_cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      last_idx_q  <= 3'd4;
      hold_cnt_q  <= '0;
      gnt_o       <= '0;
      gnt_idx_o   <= '0;
      gnt_valid_o <= 1'b0;
      timeout_o   <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_idx_q  <= last_idx_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_o       <= gnt_d;
      gnt_idx_o   <= gnt_idx_d;
      gnt_valid_o <= gnt_valid_d;
      timeout_o   <= timeout_d;
    end
  end

endmodule

// File: tb/tb_rr_arbiter_5req.sv
// Bench for rr_arbiter_5req: vector table, corner-case sequences, then random traffic against a rotation model.
module tb_rr_arbiter_5req;

  localparam int MH = 4;

  logic       clk;
  logic       rst_n;
  logic [4:0] req;
  logic       done;
  logic [4:0] gnt;
  logic [2:0] gnt_idx;
  logic       gnt_valid;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  rr_arbiter_5req #(.MAX_HOLD(MH), .CNT_W(8)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .req_i      (req),
    .done_i     (done),
    .gnt_o      (gnt),
    .gnt_idx_o  (gnt_idx),
    .gnt_valid_o(gnt_valid),
    .timeout_o  (timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    bit         rst;
    logic [4:0] req;
    logic       done;
    logic [9:0] exp;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [9:0] pk(input logic [4:0] g, input logic [2:0] idx,
                                    input logic v, input logic t);
    return {g, idx, v, t};
  endfunction

  function automatic logic [9:0] exp_gnt(input int k);
    logic [4:0] g;
    g = 5'b00001 << k;
    return pk(g, 3'(k), 1'b1, 1'b0);
  endfunction

  function automatic logic [9:0] obs();
    return {gnt, gnt_idx, gnt_valid, timeout};
  endfunction

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got gnt=%b idx=%0d vld=%b tmo=%b, want gnt=%b idx=%0d vld=%b tmo=%b",
               name, act[9:5], act[4:2], act[1], act[0], exp[9:5], exp[4:2], exp[1], exp[0]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Async reset pulse placed between edges (called 1 time unit after an edge).
  task automatic pulse_reset();
    req   = '0;
    done  = 1'b0;
    #1 rst_n = 1'b0;
    #1 check("reset_outputs", obs(), '0);
    rst_n = 1'b1;
  endtask

  task automatic add(input bit r, input logic [4:0] q, input logic d, input logic [9:0] e);
    vec_t v;
    v.rst = r; v.req = q; v.done = d; v.exp = e;
    vecs.push_back(v);
  endtask

  // Reference model: owner search walks indices last+1, last+2, ... modulo 5.
  int m_owner, m_last, m_held;
  bit m_tmo;

  task automatic model_reset();
    m_owner = -1; m_last = 4; m_held = 0; m_tmo = 0;
  endtask

  task automatic model_step(input logic [4:0] r, input logic d);
    if (m_owner < 0) begin
      m_tmo = 0;
      if (r != 0) begin
        for (int s = 1; s <= 5; s++) begin
          if (m_owner < 0 && r[(m_last + s) % 5]) m_owner = (m_last + s) % 5;
        end
        m_last = m_owner;
        m_held = 1;
      end
    end else if (d || !r[m_owner] || m_held == MH) begin
      m_tmo   = (m_held == MH) && !d && r[m_owner];
      m_owner = -1;
      m_held  = 0;
    end else begin
      m_held++;
      m_tmo = 0;
    end
  endtask

  function automatic logic [9:0] model_exp();
    if (m_owner < 0) return pk(5'b0, 3'd0, 1'b0, m_tmo);
    return exp_gnt(m_owner);
  endfunction

  initial begin
    rst_n = 1'b0;
    req   = '0;
    done  = 1'b0;
    #3 check("reset_state", obs(), '0);
    tick();
    rst_n = 1'b1;

    // Single request, done release.
    add(1, 5'b10110, 0, exp_gnt(1));
    add(0, 5'b10110, 1, '0);
    add(0, 5'b00000, 0, '0);
    // Full-load rotation, done in each owner's second cycle.
    for (int g = 0; g < 6; g++) begin
      add(g == 0, 5'b11111, 0, exp_gnt(g % 5));
      add(0,      5'b11111, 0, exp_gnt(g % 5));
      add(0,      5'b11111, 1, '0);
    end
    // Request drop and wrap-around from 4 back to 0.
    add(1, 5'b10001, 0, exp_gnt(0));
    add(0, 5'b10000, 0, '0);
    add(0, 5'b10000, 0, exp_gnt(4));
    add(0, 5'b10001, 1, '0);
    add(0, 5'b10001, 0, exp_gnt(0));
    add(0, 5'b10001, 1, '0);

    foreach (vecs[i]) begin
      if (vecs[i].rst) pulse_reset();
      req  = vecs[i].req;
      done = vecs[i].done;
      tick();
      check($sformatf("vec%0d", i), obs(), vecs[i].exp);
    end

    // Hold-limit timeout, then immediate re-grant.
    pulse_reset();
    req = 5'b00001;
    for (int c = 0; c < MH; c++) begin
      tick();
      check($sformatf("hold_cycle%0d", c), obs(), exp_gnt(0));
    end
    tick();
    check("timeout_pulse", obs(), pk(5'b0, 3'd0, 1'b0, 1'b1));
    tick();
    check("regrant_after_timeout", obs(), exp_gnt(0));

    // Done coinciding with the limit suppresses timeout.
    pulse_reset();
    req = 5'b00001;
    repeat (MH) tick();
    done = 1'b1;
    tick();
    check("done_at_limit", obs(), '0);
    done = 1'b0;

    // Request drop coinciding with the limit suppresses timeout.
    pulse_reset();
    req = 5'b00010;
    repeat (MH) tick();
    req = 5'b00000;
    tick();
    check("drop_at_limit", obs(), '0);

    // Reset mid-grant clears outputs asynchronously and restores pointer.
    pulse_reset();
    req = 5'b00100;
    tick();
    check("owner2_granted", obs(), exp_gnt(2));
    req = 5'b11111;
    tick();
    check("owner2_held", obs(), exp_gnt(2));
    #2 rst_n = 1'b0;
    #1 check("async_reset_mid_grant", obs(), '0);
    rst_n = 1'b1;
    tick();
    check("first_grant_after_reset", obs(), exp_gnt(0));

    // Random traffic against the model.
    pulse_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(299) == 0) begin
        pulse_reset();
        model_reset();
      end
      if ($urandom_range(3) == 0) req = 5'($urandom_range(31));
      done = ($urandom_range(5) == 0);
      model_step(req, done);
      tick();
      check($sformatf("rand%0d", n), obs(), model_exp());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rr_arbiter_5req.md
# rr_arbiter_5req

Round-robin arbiter that shares one single-user resource among five requesters. It uses the same LSB-first 5-bit priority encoding as the rest of the datapath, with the rotating priority supplied by a registered last-grant pointer. The grant is held until the owner signals completion, drops its request, or exceeds a hold limit. The block sits in front of the shared resource and drives its owner-select from `gnt_idx_o`.

## Interface
- `MAX_HOLD`, default 15: maximum consecutive cycles a single grant may stay asserted. Legal range is 1..255.
- `CNT_W`, default 8: width of the hold counter. Must satisfy 2^CNT_W > MAX_HOLD.

- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rst_ni`  in  1  reset, asynchronous assert, active-low; synchronous deassert is provided externally.
- `req_i`  in  5  level request per requester; bit k is requester k.
- `done_i`  in  1  current owner ends its transaction; sampled only in BUSY.
- `gnt_o`  out  5  registered one-hot grant; all zero when no grant.
- `gnt_idx_o`  out  3  registered index of the owner (0..4); 0 when no grant.
- `gnt_valid_o`  out  1  registered; 1 exactly when `gnt_o` is nonzero.
- `timeout_o`  out  1  registered one-cycle pulse when a grant was forcibly released by the hold limit.

## Operation
- **State machine:** two states, IDLE and BUSY. Reset state is IDLE.
- **Registers:**
  - `last_idx` (3 bits) resets to 4, so requester 0 has top priority after reset.
  - `hold_cnt` (CNT_W bits) resets to 0.
- **Arbitration** is combinational, evaluated in IDLE only:
  - `mask` = requesters with index > `last_idx`. Valid only for 0..4; `last_idx` = 4 gives an empty mask.
  - If `req_i & mask` is nonzero, the winner is its lowest set bit.
  - Otherwise the winner is the lowest set bit of `req_i`.
  - If `req_i` is zero, there is no winner.
- **IDLE:**
  - If there is a winner: next state BUSY; `gnt_o` = one-hot(winner); `gnt_idx_o` = winner; `gnt_valid_o` = 1; `last_idx` = winner; `hold_cnt` = 0.
  - Otherwise all outputs stay 0.
- **BUSY, release condition.** The grant is released when any of the following is true:
  - `done_i` = 1;
  - `req_i[gnt_idx_o]` = 0;
  - `hold_cnt` == MAX_HOLD-1.
- **BUSY, on release:** next state IDLE; `gnt_o`, `gnt_idx_o` and `gnt_valid_o` clear to 0; `hold_cnt` = 0.
  - `timeout_o` = 1 only if the hold limit was the sole release cause. If `done_i` or a request drop coincides with the limit, `timeout_o` = 0.
- **BUSY, otherwise:** `hold_cnt` increments by 1 and the grant outputs hold.
- **Non-owner requests:** changes to other requesters' `req_i` bits have no effect while in BUSY.
- **Invariants:**
  - `gnt_o` is never multi-hot.
  - `gnt_valid_o` equals the OR-reduction of `gnt_o`.
  - `gnt_idx_o` matches the bit set in `gnt_o`.
- **Reset mid-grant:** all outputs and state return to reset values immediately (asynchronously); `last_idx` = 4.

## Timing
- **Reset values:** `gnt_o` = 5'b00000, `gnt_idx_o` = 0, `gnt_valid_o` = 0, `timeout_o` = 0.
- **Request-to-grant latency:** 1 cycle. A request sampled at edge n in IDLE has its grant visible after edge n.
- **Grant length:** at most MAX_HOLD cycles, at least 1 cycle (when `done_i` is high in the first BUSY cycle).
- **Release-to-clear latency:** 1 cycle. The release condition sampled at edge n clears the grant after edge n.
- **Turnaround:** every release is followed by exactly one IDLE cycle with `gnt_valid_o` = 0. The minimum period between two grant starts is grant length + 1.
- **`timeout_o` alignment:** high during the first cycle after the grant drops (the IDLE cycle), and low otherwise.
- **Fairness bound:** with all five requesters continuously requesting, each is granted once per five grants. Worst-case wait is 4 × (MAX_HOLD + 1) + 1 cycles.

## Test plan
1. **Reset then single request:** reset, then `req_i` = 5'b10110 → after 1 edge `gnt_o` = 5'b00010, `gnt_idx_o` = 1; hold `req_i`, pulse `done_i` → one cycle later `gnt_o` = 0.
2. **Full-load rotation:** `req_i` = 5'b11111 continuously, `done_i` on every owner's second BUSY cycle → grant indices 0,1,2,3,4,0 in order. Each grant lasts 2 cycles, separated by one idle cycle; `timeout_o` stays 0.
3. **Hold-limit timeout:** MAX_HOLD = 4, `req_i` = 5'b00001 held, `done_i` = 0 → `gnt_o` = 5'b00001 for exactly 4 cycles, then `timeout_o` = 1 for one cycle with `gnt_o` = 0, then requester 0 is granted again.
4. **Wrap-around and request drop:** from reset, `req_i` = 5'b10001 → grant 0. Drop bit 0 → grant clears, no timeout. Next grant goes to 4; then raise bit 0 and release → grant 0 (pointer wraps).
5. **Simultaneous release causes:** MAX_HOLD = 4, `done_i` asserted in the 4th grant cycle → grant clears and `timeout_o` stays 0.
6. **Reset mid-grant:** with requester 2 granted, pulse `rst_ni` low mid-cycle → outputs go to 0 before the next edge. After release with `req_i` = 5'b11111, the first grant is to 0.
